// File: rtl/huff_pkg.sv
// Shared types and sizing for the three-symbol Huffman encoder tile.
// Optional debug feature: define HUFF_STATE_OUT_EN to expose the FSM state on io_out[11:9].
package huff_pkg;

  localparam int NUM_SYMS = 3;
  localparam int FREQ_W   = 3;
  localparam int CHAR_W   = 8;
  localparam int CODE_W   = 2;
  localparam int WEIGHT_W = 5;
  localparam int IDX_W    = 2;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    BUILD  = 2'd1,
    ENCODE = 2'd2,
    OUT    = 2'd3
  } state_t;

  typedef struct packed {
    logic [WEIGHT_W-1:0] weight;
    logic [IDX_W-1:0]    idx;
    logic                is_leaf;
  } node_t;

  // Strict ordering used everywhere a "smaller" node is chosen: weight first,
  // then a leaf beats an internal node, then the lower slot index wins.
  function automatic logic node_less(input node_t x, input node_t y);
    logic lt;
    if (x.weight != y.weight) begin
      lt = (x.weight < y.weight);
    end else if (x.is_leaf != y.is_leaf) begin
      lt = x.is_leaf;
    end else begin
      lt = (x.idx < y.idx);
    end
    return lt;
  endfunction

endpackage

// File: rtl/huff_encoder_sort3.sv
// Combinational stable ascending sort of three frequencies; returns slot indices
// lowest first. Ties in frequency resolve to the lower slot index.
module huff_encoder_sort3
  import huff_pkg::*;
(
  input  logic [NUM_SYMS-1:0][FREQ_W-1:0] freq,
  output logic [NUM_SYMS-1:0][IDX_W-1:0]  order
);

  node_t      leaf [NUM_SYMS];
  logic [1:0] rank [NUM_SYMS];

  // Wrap each frequency as a leaf node so the shared ordering rule applies.
  always_comb begin
    for (int i = 0; i < NUM_SYMS; i++) begin
      leaf[i].weight  = WEIGHT_W'(freq[i]);
      leaf[i].idx     = IDX_W'(i);
      leaf[i].is_leaf = 1'b1;
    end
  end

  // Rank of a slot is the number of other slots that sort strictly before it.
  always_comb begin
    for (int i = 0; i < NUM_SYMS; i++) begin
      rank[i] = 2'd0;
      for (int j = 0; j < NUM_SYMS; j++) begin
        if ((j != i) && node_less(leaf[j], leaf[i])) begin
          rank[i] = rank[i] + 2'd1;
        end
      end
    end
  end

  // Scatter slot indices into their sorted positions (ranks are a permutation).
  always_comb begin
    order = '0;
    for (int i = 0; i < NUM_SYMS; i++) begin
      order[rank[i]] = IDX_W'(i);
    end
  end

endmodule

// File: rtl/huff_encoder.sv
// Three-symbol Huffman encoder on a 12-bit pin bus: loads {freq,char} triples,
// builds the tree, then streams char and mask/value words for each slot.
// Optional debug feature: define HUFF_STATE_OUT_EN to drive io_out[11:9] with the FSM state.
module huff_encoder
  import huff_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] io_in,
  output logic [11:0] io_out
);

  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] word_q, word_d;
  logic [NUM_SYMS-1:0][FREQ_W-1:0] freq_q, freq_d;
  logic [NUM_SYMS-1:0][CHAR_W-1:0] char_q, char_d;
  logic [NUM_SYMS-1:0][CODE_W-1:0] mask_q, mask_d;
  logic [NUM_SYMS-1:0][CODE_W-1:0] value_q, value_d;
  logic [IDX_W-1:0] lo_idx_q, lo_idx_d;
  logic [IDX_W-1:0] hi_idx_q, hi_idx_d;
  node_t node_m_q, node_m_d;
  node_t node_c_q, node_c_d;
  logic [11:0] io_out_q, io_out_d;

  logic [NUM_SYMS-1:0][IDX_W-1:0] sort_order;
  logic [IDX_W-1:0] out_slot;
  logic c_first;

  huff_encoder_sort3 u_sort (
    .freq  (freq_q),
    .order (sort_order)
  );

  assign out_slot = word_q[2:1];
  assign c_first  = node_less(node_c_q, node_m_q);
  assign io_out   = io_out_q;

  // Next-state, table and output-word computation for the LOAD/BUILD/ENCODE/OUT sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    freq_d   = freq_q;
    char_d   = char_q;
    mask_d   = mask_q;
    value_d  = value_q;
    lo_idx_d = lo_idx_q;
    hi_idx_d = hi_idx_q;
    node_m_d = node_m_q;
    node_c_d = node_c_q;
    io_out_d = '0;

    case (state_q)
      LOAD: begin
        if (io_in[11]) begin
          freq_d[cnt_q] = io_in[10:8];
          char_d[cnt_q] = io_in[7:0];
          if (cnt_q == 2'(NUM_SYMS - 1)) begin
            cnt_d   = 2'd0;
            state_d = BUILD;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      BUILD: begin
        lo_idx_d         = sort_order[0];
        hi_idx_d         = sort_order[1];
        node_m_d.weight  = WEIGHT_W'(freq_q[sort_order[0]]) + WEIGHT_W'(freq_q[sort_order[1]]);
        node_m_d.idx     = '1;
        node_m_d.is_leaf = 1'b0;
        node_c_d.weight  = WEIGHT_W'(freq_q[sort_order[2]]);
        node_c_d.idx     = sort_order[2];
        node_c_d.is_leaf = 1'b1;
        state_d          = ENCODE;
      end
      ENCODE: begin
        mask_d[node_c_q.idx]  = 2'b01;
        value_d[node_c_q.idx] = {1'b0, ~c_first};
        mask_d[lo_idx_q]      = 2'b11;
        value_d[lo_idx_q]     = {c_first, 1'b0};
        mask_d[hi_idx_q]      = 2'b11;
        value_d[hi_idx_q]     = {c_first, 1'b1};
        word_d                = 3'd0;
        state_d               = OUT;
      end
      OUT: begin
        io_out_d[8] = 1'b1;
        if (word_q[0]) begin
          io_out_d[7:0] = {{(CHAR_W - 2*CODE_W){1'b0}}, mask_q[out_slot], value_q[out_slot]};
        end else begin
          io_out_d[7:0] = char_q[out_slot];
        end
        if (word_q == 3'd5) begin
          word_d  = 3'd0;
          state_d = LOAD;
        end else begin
          word_d = word_q + 3'd1;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

`ifdef HUFF_STATE_OUT_EN
    io_out_d[11:9] = {1'b0, state_d};
`else
    io_out_d[11:9] = 3'b000;
`endif
  end

  // State and table registers; reset aborts any operation and clears every table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD;
      cnt_q    <= 2'd0;
      word_q   <= 3'd0;
      freq_q   <= '0;
      char_q   <= '0;
      mask_q   <= '0;
      value_q  <= '0;
      lo_idx_q <= '0;
      hi_idx_q <= '0;
      node_m_q <= '0;
      node_c_q <= '0;
      io_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      freq_q   <= freq_d;
      char_q   <= char_d;
      mask_q   <= mask_d;
      value_q  <= value_d;
      lo_idx_q <= lo_idx_d;
      hi_idx_q <= hi_idx_d;
      node_m_q <= node_m_d;
      node_c_q <= node_c_d;
      io_out_q <= io_out_d;
    end
  end

endmodule

// File: tb/tb_huff_encoder.sv
// Directed testbench for huff_encoder: table of hand-computed code tables plus
// sequences for valid gaps, back-to-back loads and reset during LOAD/OUT.
module tb_huff_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] io_in;
  logic [11:0] io_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0][2:0] freq;
    logic [2:0][7:0] chr;
    logic [5:0][7:0] words;
  } vec_t;

  vec_t vecs [9];

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  huff_encoder dut (
    .clk    (clk),
    .reset  (reset),
    .io_in  (io_in),
    .io_out (io_out)
  );

  // Builds one vector record; w lists the six expected payloads, word 0 first.
  function automatic vec_t mkVec(input logic [2:0] f0, input logic [2:0] f1, input logic [2:0] f2,
                                 input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                                 input logic [47:0] w);
    vec_t v;
    v.freq[0] = f0;
    v.freq[1] = f1;
    v.freq[2] = f2;
    v.chr[0]  = c0;
    v.chr[1]  = c1;
    v.chr[2]  = c2;
    for (int k = 0; k < 6; k++) begin
      v.words[k] = w[47 - 8*k -: 8];
    end
    return v;
  endfunction

  // Compares io_out against the expected valid+payload; the debug field is only checked when tied off.
  task automatic checkWord(input string name, input logic [8:0] exp);
    logic [11:0] got;
    logic [11:0] want;
    got  = io_out;
    want = {3'b000, exp};
`ifdef HUFF_STATE_OUT_EN
    got[11:9] = 3'b000;
`endif
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Drives the three symbols of a vector, optionally with idle/garbage cycles between them.
  task automatic applyStimulus(input vec_t v, input int gap, input bit noFirstWait);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          @(negedge clk);
          io_in = {1'b0, 11'($urandom)};
        end
      end
      if (!(i == 0 && noFirstWait)) @(negedge clk);
      io_in = {1'b1, v.freq[i], v.chr[i]};
    end
    @(negedge clk);
    io_in = '0;
  endtask

  // Called right after the 3rd accept: two quiet cycles, then the six words in order.
  task automatic checkOutput(input vec_t v, input bit noise, input string tag);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (noise) io_in = {1'b1, 11'($urandom)};
      checkWord($sformatf("%s lat%0d", tag, c), 9'h000);
    end
    for (int w = 0; w < 6; w++) begin
      @(negedge clk);
      if (noise) io_in = (w == 5) ? 12'h000 : {1'b1, 11'($urandom)};
      checkWord($sformatf("%s word%0d", tag, w), {1'b1, v.words[w]});
    end
  endtask

  // One cycle after word 5 the bus must be idle again.
  task automatic checkIdle(input string tag);
    @(negedge clk);
    checkWord($sformatf("%s idle", tag), 9'h000);
  endtask

  // Main sequence: reset, table sweep, then the multi-cycle corner cases.
  initial begin
    vecs[0] = mkVec(3'd1, 3'd2, 3'd3, 8'h61, 8'h62, 8'h63, 48'h61_0E_62_0F_63_04);
    vecs[1] = mkVec(3'd4, 3'd1, 3'd1, 8'h78, 8'h79, 8'h7A, 48'h78_05_79_0C_7A_0D);
    vecs[2] = mkVec(3'd2, 3'd2, 3'd2, 8'h11, 8'h22, 8'h33, 48'h11_0E_22_0F_33_04);
    vecs[3] = mkVec(3'd3, 3'd0, 3'd7, 8'hA0, 8'hB1, 8'hC2, 48'hA0_0D_B1_0C_C2_05);
    vecs[4] = mkVec(3'd7, 3'd7, 3'd7, 8'hFF, 8'h00, 8'h80, 48'hFF_0E_00_0F_80_04);
    vecs[5] = mkVec(3'd5, 3'd6, 3'd2, 8'h01, 8'h02, 8'h03, 48'h01_0F_02_04_03_0E);
    vecs[6] = mkVec(3'd0, 3'd0, 3'd0, 8'h41, 8'h42, 8'h43, 48'h41_0E_42_0F_43_04);
    vecs[7] = mkVec(3'd1, 3'd1, 3'd3, 8'h10, 8'h20, 8'h30, 48'h10_0C_20_0D_30_05);
    vecs[8] = mkVec(3'd2, 3'd1, 3'd3, 8'hD0, 8'hD1, 8'hD2, 48'hD0_0F_D1_0E_D2_04);

    reset = 1'b1;
    io_in = '0;
    repeat (2) @(negedge clk);
    checkWord("reset", 9'h000);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], 0, 1'b0);
      checkOutput(vecs[i], (i == 3), $sformatf("vec%0d", i));
      checkIdle($sformatf("vec%0d", i));
    end

    applyStimulus(vecs[1], 3, 1'b0);
    checkOutput(vecs[1], 1'b0, "gap");
    checkIdle("gap");

    applyStimulus(vecs[0], 0, 1'b0);
    checkOutput(vecs[0], 1'b0, "b2b_first");
    applyStimulus(vecs[5], 0, 1'b1);
    checkOutput(vecs[5], 1'b0, "b2b_second");
    checkIdle("b2b");

    applyStimulus(vecs[4], 0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checkWord("rst_out", 9'h000);
    @(negedge clk);
    checkWord("rst_out_hold", 9'h000);
    reset = 1'b0;
    applyStimulus(vecs[7], 0, 1'b0);
    checkOutput(vecs[7], 1'b0, "after_rst_out");
    checkIdle("after_rst_out");

    @(negedge clk);
    io_in = {1'b1, 3'd7, 8'hEE};
    @(negedge clk);
    io_in = {1'b1, 3'd6, 8'hDD};
    @(negedge clk);
    io_in = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkWord("rst_load", 9'h000);
    applyStimulus(vecs[8], 0, 1'b0);
    checkOutput(vecs[8], 1'b0, "after_rst_load");
    checkIdle("after_rst_load");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
